reg_ext_dispatch: RTL and testbench



---
 rtl/reg_ext_dispatch.sv | 159 +++++++++++++++
 tb/tb_reg_ext_dispatch.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_ext_dispatch.sv
// reg_ext_dispatch: routes the upstream single-outstanding register request to one of SLV_NUM external slaves.
// Optional macro REG_EXT_DISPATCH_RSP_PIPE_EN registers the hit response (default: slave ack bypassed upstream).
module reg_ext_dispatch #(
   parameter int                    ADDR_WIDTH = 64,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    SLV_NUM    = 4,
   parameter int                    WIN_BITS   = 12,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
   parameter logic [DATA_WIDTH-1:0] MISS_DATA  = DATA_WIDTH'(32'hdead_0add)
) (
   input  logic                          PCLK,
   input  logic                          PRESETn,
   input  logic                          fsm__slv__req_vld,
   input  logic [ADDR_WIDTH-1:0]         fsm__slv__addr,
   input  logic [DATA_WIDTH-1:0]         fsm__slv__wr_data,
   input  logic                          fsm__slv__wr_en,
   input  logic                          fsm__slv__rd_en,
   input  logic                          fsm__slv__sync_reset,
   output logic                          slv__fsm__ack_vld,
   output logic [DATA_WIDTH-1:0]         slv__fsm__rd_data,
   output logic [SLV_NUM-1:0]            disp__ext__req_vld,
   output logic [ADDR_WIDTH-1:0]         disp__ext__addr,
   output logic [DATA_WIDTH-1:0]         disp__ext__wr_data,
   output logic                          disp__ext__wr_en,
   output logic                          disp__ext__rd_en,
   output logic                          disp__ext__sync_reset,
   input  logic [SLV_NUM-1:0]            ext__disp__ack_vld,
   input  logic [SLV_NUM*DATA_WIDTH-1:0] ext__disp__rd_data
);

   localparam int                    SEL_W       = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
   localparam logic [ADDR_WIDTH-1:0] OFF_MASK    = (ADDR_WIDTH'(1) << WIN_BITS) - ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] REGION_MASK = ~((ADDR_WIDTH'(1) << (WIN_BITS + SEL_W)) - ADDR_WIDTH'(1));
   localparam logic [SEL_W:0]        SLV_NUM_C   = (SEL_W + 1)'(SLV_NUM);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_RESP = 2'd3
   } state_e;

   state_e                state_q;
   logic                  req_prev_q;
   logic [SEL_W-1:0]      idx_q;
   logic                  ack_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic [SLV_NUM-1:0]    ext_req_q;
   logic [ADDR_WIDTH-1:0] ext_addr_q;
   logic [DATA_WIDTH-1:0] ext_wdata_q;
   logic                  ext_wr_q;
   logic                  ext_rd_q;
   logic                  sync_q;

   logic [SEL_W-1:0]      dec_idx_s;
   logic                  dec_hit_s;
   logic                  accept_s;
   logic                  sel_ack_s;
   logic [DATA_WIDTH-1:0] sel_data_s;

   // Decode of the incoming request and selection of the dispatched slave's ack and data.
   always_comb begin
      dec_idx_s  = fsm__slv__addr[WIN_BITS +: SEL_W];
      dec_hit_s  = ((fsm__slv__addr & REGION_MASK) == (BASE_ADDR & REGION_MASK))
                && ({1'b0, dec_idx_s} < SLV_NUM_C)
                && (fsm__slv__wr_en ^ fsm__slv__rd_en);
      accept_s   = (state_q == S_IDLE) && fsm__slv__req_vld && !req_prev_q && !fsm__slv__sync_reset;
      sel_ack_s  = 1'b0;
      sel_data_s = '0;
      for (int i = 0; i < SLV_NUM; i++) begin
         sel_ack_s  = sel_ack_s | ((idx_q == SEL_W'(i)) & ext__disp__ack_vld[i]);
         sel_data_s = sel_data_s
                    | ({DATA_WIDTH{idx_q == SEL_W'(i)}} & ext__disp__rd_data[i*DATA_WIDTH +: DATA_WIDTH]);
      end
   end

   // Request FSM with registered dispatch, response and sync-reset forwarding.
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         state_q     <= S_IDLE;
         req_prev_q  <= 1'b0;
         idx_q       <= '0;
         ack_q       <= 1'b0;
         rdata_q     <= '0;
         ext_req_q   <= '0;
         ext_addr_q  <= '0;
         ext_wdata_q <= '0;
         ext_wr_q    <= 1'b0;
         ext_rd_q    <= 1'b0;
         sync_q      <= 1'b0;
      end else begin
         req_prev_q <= fsm__slv__req_vld;
         sync_q     <= fsm__slv__sync_reset;
         ext_req_q  <= '0;
         ack_q      <= 1'b0;
         rdata_q    <= '0;
         if (fsm__slv__sync_reset) begin
            state_q <= S_IDLE;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (accept_s) begin
                     ext_addr_q  <= fsm__slv__addr & OFF_MASK;
                     ext_wdata_q <= fsm__slv__wr_data;
                     ext_wr_q    <= fsm__slv__wr_en;
                     ext_rd_q    <= fsm__slv__rd_en;
                     idx_q       <= dec_idx_s;
                     if (dec_hit_s) begin
                        ext_req_q <= SLV_NUM'(1) << dec_idx_s;
                        state_q   <= S_REQ;
                     end else begin
                        // Misses (including ambiguous direction) are answered locally.
                        ack_q   <= 1'b1;
                        rdata_q <= (fsm__slv__rd_en && !fsm__slv__wr_en) ? MISS_DATA : '0;
                        state_q <= S_RESP;
                     end
                  end else begin
                     state_q <= S_IDLE;
                  end
               end
               S_REQ, S_WAIT: begin
                  if (sel_ack_s) begin
`ifdef REG_EXT_DISPATCH_RSP_PIPE_EN
                     ack_q   <= 1'b1;
                     rdata_q <= ext_rd_q ? sel_data_s : '0;
                     state_q <= S_RESP;
`else
                     state_q <= S_IDLE;
`endif
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
               S_RESP:  state_q <= S_IDLE;
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

   assign disp__ext__req_vld    = ext_req_q;
   assign disp__ext__addr       = ext_addr_q;
   assign disp__ext__wr_data    = ext_wdata_q;
   assign disp__ext__wr_en      = ext_wr_q;
   assign disp__ext__rd_en      = ext_rd_q;
   assign disp__ext__sync_reset = sync_q;

`ifdef REG_EXT_DISPATCH_RSP_PIPE_EN
   assign slv__fsm__ack_vld = ack_q;
   assign slv__fsm__rd_data = rdata_q;
`else
   logic byp_ack_s;
   // Hit responses bypass RESP: the selected slave's ack goes straight upstream unless aborted.
   assign byp_ack_s = ((state_q == S_REQ) || (state_q == S_WAIT)) && sel_ack_s && !fsm__slv__sync_reset;
   assign slv__fsm__ack_vld = ack_q | byp_ack_s;
   assign slv__fsm__rd_data = ack_q ? rdata_q : ((byp_ack_s && ext_rd_q) ? sel_data_s : '0);
`endif

endmodule

// File: tb/tb_reg_ext_dispatch.sv
// Self-checking bench for reg_ext_dispatch: reactive slave models plus a transaction-level reference model.
module tb_reg_ext_dispatch;
   localparam int          NS   = 4;
   localparam logic [63:0] BASE = 64'h0;
   localparam logic [31:0] MISS = 32'hdead_0add;
`ifdef REG_EXT_DISPATCH_RSP_PIPE_EN
   localparam int PIPE = 1;
`else
   localparam int PIPE = 0;
`endif

   logic          PCLK = 1'b0;
   logic          PRESETn = 1'b0;
   logic          fsm__slv__req_vld;
   logic [63:0]   fsm__slv__addr;
   logic [31:0]   fsm__slv__wr_data;
   logic          fsm__slv__wr_en;
   logic          fsm__slv__rd_en;
   logic          fsm__slv__sync_reset;
   logic          slv__fsm__ack_vld;
   logic [31:0]   slv__fsm__rd_data;
   logic [3:0]    disp__ext__req_vld;
   logic [63:0]   disp__ext__addr;
   logic [31:0]   disp__ext__wr_data;
   logic          disp__ext__wr_en;
   logic          disp__ext__rd_en;
   logic          disp__ext__sync_reset;
   logic [3:0]    ext__disp__ack_vld;
   logic [127:0]  ext__disp__rd_data;

   int total = 0;
   int bad = 0;

   int          obs_ack_cnt, obs_ack_cyc, obs_req_cnt, obs_req_cyc, obs_rd_nz, obs_sync_cnt, obs_sync_cyc;
   logic [31:0] obs_ack_data;
   logic [3:0]  obs_req_val;
   logic [63:0] obs_addr;
   logic [31:0] obs_wdata;
   logic        obs_wr, obs_rd;
   logic [31:0] sd [4];

   reg_ext_dispatch dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .fsm__slv__req_vld(fsm__slv__req_vld), .fsm__slv__addr(fsm__slv__addr),
      .fsm__slv__wr_data(fsm__slv__wr_data), .fsm__slv__wr_en(fsm__slv__wr_en),
      .fsm__slv__rd_en(fsm__slv__rd_en), .fsm__slv__sync_reset(fsm__slv__sync_reset),
      .slv__fsm__ack_vld(slv__fsm__ack_vld), .slv__fsm__rd_data(slv__fsm__rd_data),
      .disp__ext__req_vld(disp__ext__req_vld), .disp__ext__addr(disp__ext__addr),
      .disp__ext__wr_data(disp__ext__wr_data), .disp__ext__wr_en(disp__ext__wr_en),
      .disp__ext__rd_en(disp__ext__rd_en), .disp__ext__sync_reset(disp__ext__sync_reset),
      .ext__disp__ack_vld(ext__disp__ack_vld), .ext__disp__rd_data(ext__disp__rd_data)
   );

   always #5 PCLK = ~PCLK;

   // Reference decode: inside the region, slave index in range, exactly one direction bit.
   function automatic bit model_hit(input logic [63:0] a, input logic wr, input logic rd);
      return ((a / 64'h4000) == (BASE / 64'h4000)) && (((a / 64'h1000) % 64'd4) < 64'(NS)) && (wr != rd);
   endfunction

   // One upstream transaction; cycle 0 is the cycle in which req_vld rises.
   task automatic run_txn(input logic [63:0] a, input logic [31:0] wd, input logic wr, input logic rd,
                          input int k, input int sp_cyc, input int hold, input int sync_at,
                          input bit fix_en, input logic [31:0] fix_data);
      int drop_cyc, stop_cyc;
      int pend [4];
      for (int i = 0; i < 4; i++) begin
         pend[i] = -1;
         sd[i]   = $urandom;
      end
      if (fix_en) sd[int'((a / 64'h1000) % 64'd4)] = fix_data;
      obs_ack_cnt = 0; obs_ack_cyc = -1; obs_req_cnt = 0; obs_req_cyc = -1;
      obs_rd_nz = 0; obs_sync_cnt = 0; obs_sync_cyc = -1;
      obs_ack_data = 32'h0; obs_req_val = 4'h0; obs_addr = 64'h0; obs_wdata = 32'h0;
      obs_wr = 1'b0; obs_rd = 1'b0;
      ext__disp__rd_data   = {sd[3], sd[2], sd[1], sd[0]};
      ext__disp__ack_vld   = 4'h0;
      fsm__slv__addr       = a;
      fsm__slv__wr_data    = wd;
      fsm__slv__wr_en      = wr;
      fsm__slv__rd_en      = rd;
      fsm__slv__sync_reset = 1'b0;
      fsm__slv__req_vld    = 1'b1;
      @(posedge PCLK); #1;
      drop_cyc = 40;
      stop_cyc = 40;
      for (int c = 1; c <= stop_cyc; c++) begin
         fsm__slv__req_vld    = (c < drop_cyc);
         fsm__slv__sync_reset = (c == sync_at);
         if (disp__ext__req_vld != 4'h0) begin
            obs_req_cnt++;
            if (obs_req_cyc < 0) begin
               obs_req_cyc = c;
               obs_req_val = disp__ext__req_vld;
               obs_addr    = disp__ext__addr;
               obs_wdata   = disp__ext__wr_data;
               obs_wr      = disp__ext__wr_en;
               obs_rd      = disp__ext__rd_en;
            end
            for (int i = 0; i < 4; i++) if (disp__ext__req_vld[i]) pend[i] = c + k;
         end
         if (disp__ext__sync_reset) begin
            obs_sync_cnt++;
            if (obs_sync_cyc < 0) obs_sync_cyc = c;
         end
         for (int i = 0; i < 4; i++) ext__disp__ack_vld[i] = (pend[i] == c) || (i == 3 && c == sp_cyc);
         #1;
         if (slv__fsm__ack_vld) begin
            obs_ack_cnt++;
            if (obs_ack_cyc < 0) begin
               obs_ack_cyc  = c;
               obs_ack_data = slv__fsm__rd_data;
               if (sync_at == 0) begin
                  drop_cyc = c + 1 + hold;
                  stop_cyc = drop_cyc;
               end
            end
         end else if (slv__fsm__rd_data != 32'h0) begin
            obs_rd_nz++;
         end
         if (sync_at != 0 && c == sync_at) begin
            drop_cyc = c + 1;
            stop_cyc = c + 3;
         end
         @(posedge PCLK); #1;
      end
      fsm__slv__req_vld    = 1'b0;
      fsm__slv__sync_reset = 1'b0;
      ext__disp__ack_vld   = 4'h0;
   endtask

   task automatic test_reset();
      fsm__slv__req_vld = 1'b0; fsm__slv__addr = 64'h0; fsm__slv__wr_data = 32'h0;
      fsm__slv__wr_en = 1'b0; fsm__slv__rd_en = 1'b0; fsm__slv__sync_reset = 1'b0;
      ext__disp__ack_vld = 4'h0; ext__disp__rd_data = 128'h0;
      PRESETn = 1'b0;
      repeat (2) @(posedge PCLK);
      #1;
      total++;
      if (slv__fsm__ack_vld !== 1'b0 || slv__fsm__rd_data !== 32'h0)
         begin bad++; $display("FAIL reset_up: ack=%b data=%h want 0/0", slv__fsm__ack_vld, slv__fsm__rd_data); end
      total++;
      if (disp__ext__req_vld !== 4'h0 || disp__ext__addr !== 64'h0 || disp__ext__wr_data !== 32'h0)
         begin bad++; $display("FAIL reset_ext: req=%b addr=%h wd=%h want 0", disp__ext__req_vld, disp__ext__addr, disp__ext__wr_data); end
      total++;
      if ({disp__ext__wr_en, disp__ext__rd_en, disp__ext__sync_reset} !== 3'b000)
         begin bad++; $display("FAIL reset_ctl: wr/rd/sync=%b%b%b want 000", disp__ext__wr_en, disp__ext__rd_en, disp__ext__sync_reset); end
      PRESETn = 1'b1;
      repeat (2) @(posedge PCLK);
      #1;
   endtask

   task automatic test_read_hit();
      run_txn(64'h2010, 32'h0, 1'b0, 1'b1, 3, 0, 0, 0, 1'b1, 32'h1234_5678);
      total++;
      if (obs_req_cnt != 1 || obs_req_cyc != 1 || obs_req_val !== 4'b0100)
         begin bad++; $display("FAIL read_hit_req: cnt=%0d cyc=%0d val=%b want 1/1/0100", obs_req_cnt, obs_req_cyc, obs_req_val); end
      total++;
      if (obs_addr !== 64'h010 || obs_rd !== 1'b1 || obs_wr !== 1'b0)
         begin bad++; $display("FAIL read_hit_addr: addr=%h rd=%b wr=%b want 010/1/0", obs_addr, obs_rd, obs_wr); end
      total++;
      if (obs_ack_cnt != 1 || obs_ack_cyc != 4 + PIPE)
         begin bad++; $display("FAIL read_hit_ack: cnt=%0d cyc=%0d want 1/%0d", obs_ack_cnt, obs_ack_cyc, 4 + PIPE); end
      total++;
      if (obs_ack_data !== 32'h1234_5678 || obs_rd_nz != 0)
         begin bad++; $display("FAIL read_hit_data: data=%h nz=%0d want 12345678/0", obs_ack_data, obs_rd_nz); end
   endtask

   task automatic test_write_hit();
      run_txn(64'h1004, 32'hA5A5_A5A5, 1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 32'h0);
      total++;
      if (obs_req_val !== 4'b0010 || obs_wr !== 1'b1 || obs_wdata !== 32'hA5A5_A5A5 || obs_addr !== 64'h004)
         begin bad++; $display("FAIL write_hit_fwd: val=%b wr=%b wd=%h addr=%h want 0010/1/a5a5a5a5/004", obs_req_val, obs_wr, obs_wdata, obs_addr); end
      total++;
      if (obs_ack_cnt != 1 || obs_ack_cyc != 1 + PIPE || obs_ack_data !== 32'h0)
         begin bad++; $display("FAIL write_hit_ack: cnt=%0d cyc=%0d data=%h want 1/%0d/0", obs_ack_cnt, obs_ack_cyc, obs_ack_data, 1 + PIPE); end
   endtask

   task automatic test_miss();
      run_txn(64'h5000, 32'h0, 1'b0, 1'b1, 0, 0, 0, 0, 1'b0, 32'h0);
      total++;
      if (obs_req_cnt != 0)
         begin bad++; $display("FAIL miss_req: cnt=%0d want 0", obs_req_cnt); end
      total++;
      if (obs_ack_cnt != 1 || obs_ack_cyc != 1 || obs_ack_data !== MISS)
         begin bad++; $display("FAIL miss_ack: cnt=%0d cyc=%0d data=%h want 1/1/%h", obs_ack_cnt, obs_ack_cyc, obs_ack_data, MISS); end
   endtask

   task automatic test_sync_reset();
      run_txn(64'h0, 32'h0, 1'b0, 1'b1, 11, 0, 0, 10, 1'b0, 32'h0);
      total++;
      if (obs_ack_cnt != 0)
         begin bad++; $display("FAIL sync_no_ack: cnt=%0d want 0", obs_ack_cnt); end
      total++;
      if (obs_sync_cnt != 1 || obs_sync_cyc != 11)
         begin bad++; $display("FAIL sync_fwd: cnt=%0d cyc=%0d want 1/11", obs_sync_cnt, obs_sync_cyc); end
      total++;
      if (obs_req_cnt != 1)
         begin bad++; $display("FAIL sync_req: cnt=%0d want 1", obs_req_cnt); end
      run_txn(64'h0004, 32'h0, 1'b0, 1'b1, 1, 0, 0, 0, 1'b1, 32'h0bad_cafe);
      total++;
      if (obs_ack_cnt != 1 || obs_ack_cyc != 2 + PIPE || obs_ack_data !== 32'h0bad_cafe)
         begin bad++; $display("FAIL sync_after: cnt=%0d cyc=%0d data=%h want 1/%0d/0badcafe", obs_ack_cnt, obs_ack_cyc, obs_ack_data, 2 + PIPE); end
   endtask

   task automatic test_spurious();
      run_txn(64'h1000, 32'h0, 1'b0, 1'b1, 3, 2, 0, 0, 1'b1, 32'h5151_0001);
      total++;
      if (obs_ack_cnt != 1 || obs_ack_cyc != 4 + PIPE || obs_ack_data !== 32'h5151_0001)
         begin bad++; $display("FAIL spurious: cnt=%0d cyc=%0d data=%h want 1/%0d/51510001", obs_ack_cnt, obs_ack_cyc, obs_ack_data, 4 + PIPE); end
   endtask

   task automatic test_back_to_back();
      run_txn(64'h2100, 32'h0, 1'b0, 1'b1, 1, 0, 2, 0, 1'b0, 32'h0);
      total++;
      if (obs_ack_cnt != 1 || obs_req_cnt != 1)
         begin bad++; $display("FAIL hold_once: acks=%0d reqs=%0d want 1/1", obs_ack_cnt, obs_req_cnt); end
      run_txn(64'h3008, 32'h7777_0000, 1'b1, 1'b0, 1, 0, 0, 0, 1'b0, 32'h0);
      total++;
      if (obs_ack_cnt != 1 || obs_ack_cyc != 2 + PIPE || obs_req_val !== 4'b1000)
         begin bad++; $display("FAIL back_to_back: cnt=%0d cyc=%0d val=%b want 1/%0d/1000", obs_ack_cnt, obs_ack_cyc, obs_req_val, 2 + PIPE); end
   endtask

   task automatic test_random();
      logic [63:0] a;
      logic [31:0] wd, exp_data;
      logic [3:0]  exp_val;
      logic        wr, rd;
      bit          hit;
      int          mode, dsel, k, idx, exp_cyc;
      for (int n = 0; n < 40; n++) begin
         mode = $urandom_range(0, 5);
         if (mode < 4)       a = 64'($urandom_range(0, 16383));
         else if (mode == 4) a = {32'($urandom), 32'($urandom)} | 64'h4000;
         else                a = 64'($urandom_range(16384, 65535));
         dsel = $urandom_range(0, 7);
         if (dsel == 0)      begin wr = 1'b0; rd = 1'b0; end
         else if (dsel == 1) begin wr = 1'b1; rd = 1'b1; end
         else                begin wr = 1'(dsel % 2); rd = !wr; end
         k  = $urandom_range(0, 4);
         wd = $urandom;
         run_txn(a, wd, wr, rd, k, 0, 0, 0, 1'b0, 32'h0);
         hit      = model_hit(a, wr, rd);
         idx      = int'((a / 64'h1000) % 64'd4);
         exp_cyc  = hit ? 1 + k + PIPE : 1;
         exp_val  = 4'b0001 << idx;
         exp_data = hit ? (rd ? sd[idx] : 32'h0) : ((rd && !wr) ? MISS : 32'h0);
         total++;
         if (obs_ack_cnt != 1 || obs_ack_cyc != exp_cyc)
            begin bad++; $display("FAIL rnd_ack[%0d]: a=%h cnt=%0d cyc=%0d want 1/%0d", n, a, obs_ack_cnt, obs_ack_cyc, exp_cyc); end
         if (wr != rd) begin
            total++;
            if (obs_ack_data !== exp_data)
               begin bad++; $display("FAIL rnd_data[%0d]: a=%h got=%h want=%h", n, a, obs_ack_data, exp_data); end
         end
         total++;
         if (obs_req_cnt != int'(hit) || obs_rd_nz != 0 || obs_sync_cnt != 0)
            begin bad++; $display("FAIL rnd_req[%0d]: a=%h reqs=%0d nz=%0d sync=%0d want %0d/0/0", n, a, obs_req_cnt, obs_rd_nz, obs_sync_cnt, int'(hit)); end
         if (hit) begin
            total++;
            if (obs_req_val !== exp_val || obs_addr !== (a % 64'h1000) || obs_wdata !== wd || obs_wr !== wr || obs_rd !== rd)
               begin bad++; $display("FAIL rnd_fwd[%0d]: val=%b addr=%h wd=%h want %b/%h/%h", n, obs_req_val, obs_addr, obs_wdata, exp_val, a % 64'h1000, wd); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_read_hit();
      test_write_hit();
      test_miss();
      test_sync_reset();
      test_spurious();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
